// File: rtl/doa_tracker.sv
// Direction-of-arrival tracker: sequences measurement rounds on the mic
// cross-correlation subsystem, smooths the returned lag over the last eight
// rounds and maps the average onto a screen column for the overlay.
module doa_tracker #(
  parameter int          LAGNUM   = 10,
  parameter int          X_CENTER = 640,
  parameter int          X_STEP   = 32,
  parameter logic [23:0] TIMEOUT  = 24'd6000000
) (
  input  logic              clk_60MHz,
  input  logic              rst_n,
  input  logic              enable,
  output logic              subsys_start,
  input  logic              subsys_done,
  input  logic signed [5:0] lag_diff,
  output logic signed [5:0] lag_avg,
  output logic [10:0]       pos_x,
  output logic              pos_valid,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACCUM,
    MAP
  } state_t;

  localparam logic signed [5:0] LAG_HI = 6'(LAGNUM);
  localparam logic signed [5:0] LAG_LO = 6'(-LAGNUM);
  localparam logic [10:0]       POS_RST = 11'(X_CENTER);

  state_t              state_q, state_d;
  logic [23:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic signed [5:0]   lag_cap_q, lag_cap_d;
  logic signed [8:0]   sum_q, sum_d;
  logic [3:0]          fill_q, fill_d;
  logic [2:0]          wr_ptr_q, wr_ptr_d;
  logic signed [5:0]   lag_avg_q, lag_avg_d;
  logic [10:0]         pos_x_q, pos_x_d;
  logic                pos_valid_q, pos_valid_d;
  logic signed [5:0]   hist_q [8];
  logic signed [5:0]   hist_d [8];

  logic signed [5:0]   lag_clamp;
  logic signed [8:0]   sum_shift;
  logic signed [5:0]   avg_new;
  logic signed [31:0]  pos_calc;

  // Saturate the captured lag to the physically meaningful window, then
  // derive the floor average and its screen column from the running sum.
  always_comb begin
    if (lag_cap_q > LAG_HI) begin
      lag_clamp = LAG_HI;
    end else if (lag_cap_q < LAG_LO) begin
      lag_clamp = LAG_LO;
    end else begin
      lag_clamp = lag_cap_q;
    end
    sum_shift = sum_q >>> 3;
    avg_new   = sum_shift[5:0];
    pos_calc  = X_CENTER + (32'(avg_new) * X_STEP);
  end

  // Next-state and datapath update for the measurement round sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    lag_cap_d   = lag_cap_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    lag_avg_d   = lag_avg_q;
    pos_x_d     = pos_x_q;
    pos_valid_d = 1'b0;
    hist_d      = hist_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the terminal-count cycle still counts as on time.
        if (subsys_done) begin
          lag_cap_d = lag_diff;
          state_d   = ACCUM;
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          err_d   = 1'b1;
          state_d = enable ? START : IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ACCUM: begin
        hist_d[wr_ptr_q] = lag_clamp;
        sum_d    = sum_q + 9'(lag_clamp) - 9'(hist_q[wr_ptr_q]);
        wr_ptr_d = wr_ptr_q + 3'd1;
        if (fill_q != 4'd8) begin
          fill_d = fill_q + 4'd1;
        end
        state_d = MAP;
      end
      MAP: begin
        // Only publish once the window holds eight genuine measurements.
        if (fill_q == 4'd8) begin
          lag_avg_d   = avg_new;
          pos_x_d     = pos_calc[10:0];
          pos_valid_d = 1'b1;
        end
        state_d = enable ? START : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      lag_cap_q   <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      lag_avg_q   <= '0;
      pos_x_q     <= POS_RST;
      pos_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      lag_cap_q   <= lag_cap_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      lag_avg_q   <= lag_avg_d;
      pos_x_q     <= pos_x_d;
      pos_valid_q <= pos_valid_d;
    end
  end

  // Lag history window; cleared on reset so the running sum stays consistent.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign subsys_start = (state_q == START);
  assign lag_avg      = lag_avg_q;
  assign pos_x        = pos_x_q;
  assign pos_valid    = pos_valid_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_doa_tracker.sv
// Directed bench for doa_tracker: averaging, clamping, floor rounding,
// timeout behaviour, done/timeout priority and mid-round reset.
module tb_doa_tracker;

  logic              clk_60MHz = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              subsys_start;
  logic              subsys_done;
  logic signed [5:0] lag_diff;
  logic signed [5:0] lag_avg;
  logic [10:0]       pos_x;
  logic              pos_valid;
  logic              timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  doa_tracker #(
    .LAGNUM   (10),
    .X_CENTER (640),
    .X_STEP   (32),
    .TIMEOUT  (24'd100)
  ) dut (
    .clk_60MHz    (clk_60MHz),
    .rst_n        (rst_n),
    .enable       (enable),
    .subsys_start (subsys_start),
    .subsys_done  (subsys_done),
    .lag_diff     (lag_diff),
    .lag_avg      (lag_avg),
    .pos_x        (pos_x),
    .pos_valid    (pos_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk_60MHz = ~clk_60MHz;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_60MHz);
    #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!subsys_start && n < 300) begin
      tick();
      n++;
    end
    check_val("start_seen", int'(subsys_start), 1);
  endtask

  // One measurement round: done arrives 'delay' cycles after the start cycle.
  // Returns in the cycle where pos_valid would be high.
  task automatic do_round(input logic signed [5:0] lag, input int delay, output logic pv);
    wait_start();
    repeat (delay) tick();
    subsys_done = 1'b1;
    lag_diff    = lag;
    tick();
    subsys_done = 1'b0;
    tick();
    tick();
    pv = pos_valid;
    $display("round lag=%0d pv=%0d avg=%0d pos=%0d start=%0d err=%0d",
             lag, pv, lag_avg, pos_x, subsys_start, timeout_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_start"}, int'(subsys_start), 0);
    check_val({tag, "_pv"},    int'(pos_valid), 0);
    check_val({tag, "_avg"},   int'(lag_avg), 0);
    check_val({tag, "_pos"},   int'(pos_x), 640);
    check_val({tag, "_err"},   int'(timeout_err), 0);
  endtask

  initial begin
    logic pv;
    int   bad;

    rst_n       = 1'b0;
    enable      = 1'b0;
    subsys_done = 1'b0;
    lag_diff    = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Done during IDLE must be ignored (would otherwise add a ninth sample).
    subsys_done = 1'b1;
    lag_diff    = 6'sd5;
    tick();
    subsys_done = 1'b0;
    tick();
    check_val("idle_no_start", int'(subsys_start), 0);
    check_val("idle_no_pv", int'(pos_valid), 0);

    // Eight rounds of +3: only the eighth publishes.
    enable = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      do_round(6'sd3, 1 + (r % 3), pv);
      if (r < 8) begin
        check_val($sformatf("p3_r%0d_pv", r), int'(pv), 0);
      end
    end
    check_val("p3_pv", int'(pv), 1);
    check_val("p3_avg", int'(lag_avg), 3);
    check_val("p3_pos", int'(pos_x), 736);
    check_val("p3_restart", int'(subsys_start), 1);

    // Eight rounds of -5, then +20 clamped to +10.
    for (int r = 1; r <= 8; r++) begin
      do_round(-6'sd5, 2, pv);
    end
    check_val("m5_pv", int'(pv), 1);
    check_val("m5_avg", int'(lag_avg), -5);
    check_val("m5_pos", int'(pos_x), 480);
    do_round(6'sd20, 1, pv);
    check_val("clamp_pv", int'(pv), 1);
    check_val("clamp_avg", int'(lag_avg), -4);
    check_val("clamp_pos", int'(pos_x), 512);

    // Seven zeros leave the +10 entry in the window; then -1 replaces it.
    for (int r = 1; r <= 7; r++) begin
      do_round(6'sd0, 1, pv);
    end
    check_val("z7_avg", int'(lag_avg), 1);
    check_val("z7_pos", int'(pos_x), 672);
    do_round(-6'sd1, 1, pv);
    check_val("m1_pv", int'(pv), 1);
    check_val("m1_avg", int'(lag_avg), -1);
    check_val("m1_pos", int'(pos_x), 608);

    // Done coincident with the terminal count wins; window: -1,+2,0*6 -> sum 1.
    do_round(6'sd2, 100, pv);
    check_val("coinc_err", int'(timeout_err), 0);
    check_val("coinc_pv", int'(pv), 1);
    check_val("coinc_avg", int'(lag_avg), 0);
    check_val("coinc_pos", int'(pos_x), 640);

    // No done at all: flag at offset 101, start re-pulses there, no pos_valid.
    check_val("to_start_cycle", int'(subsys_start), 1);
    bad = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pos_valid || subsys_start || timeout_err) bad++;
    end
    check_val("to_quiet_window", bad, 0);
    tick();
    check_val("to_err", int'(timeout_err), 1);
    check_val("to_restart", int'(subsys_start), 1);
    check_val("to_pv", int'(pos_valid), 0);
    $display("timeout err=%0d start=%0d", timeout_err, subsys_start);

    // Reset clears the sticky flag and everything else, asynchronously.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    tick();
    rst_n = 1'b1;

    // Five rounds, then a reset while the sixth sits in ACCUM.
    for (int r = 1; r <= 5; r++) begin
      do_round(6'sd4, 1, pv);
      check_val($sformatf("p4_r%0d_pv", r), int'(pv), 0);
    end
    wait_start();
    tick();
    subsys_done = 1'b1;
    lag_diff    = 6'sd4;
    tick();
    subsys_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_accum");
    tick();
    check_val("rst_accum_hold_pv", int'(pos_valid), 0);
    rst_n = 1'b1;

    // Window restarts from empty: eight fresh rounds before publication.
    for (int r = 1; r <= 8; r++) begin
      do_round(6'sd6, 1, pv);
      if (r < 8) begin
        check_val($sformatf("p6_r%0d_pv", r), int'(pv), 0);
      end
    end
    check_val("p6_pv", int'(pv), 1);
    check_val("p6_avg", int'(lag_avg), 6);
    check_val("p6_pos", int'(pos_x), 832);

    // Dropping enable mid-round lets it finish, then the sequencer idles.
    wait_start();
    tick();
    enable      = 1'b0;
    subsys_done = 1'b1;
    lag_diff    = 6'sd6;
    tick();
    subsys_done = 1'b0;
    tick();
    tick();
    check_val("en_drop_pv", int'(pos_valid), 1);
    check_val("en_drop_start", int'(subsys_start), 0);
    repeat (3) tick();
    check_val("en_drop_idle", int'(subsys_start), 0);
    check_val("en_drop_avg", int'(lag_avg), 6);
    $display("enable drop avg=%0d pos=%0d", lag_avg, pos_x);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
